instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage of the five-stage CPU. It owns the program counter and a 256×21 instruction memory, and it drives `nPC`/`INS` into the IF/ID pipeline register. It honours the same `IFstall`/`IFflush` controls that IF/ID receives, and it buffers a branch redirect that arrives while the pipe is stalled. A small run-control FSM covers program loading, start and halt.

## Interface

Parameters:
- none. Widths are fixed by the ISA: 8-bit PC, 21-bit instruction, 4-bit CTRL field.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — one-cycle pulse that begins execution at PC 0. Honoured only in IDLE or HALT.
- `IFstall`  in  1  — hold PC; same signal that drives IF/ID.
- `IFflush`  in  1  — branch/jump taken; redirect PC to `brTarget`.
- `brTarget`  in  8  — redirect address; valid while `IFflush`=1.
- `progWE`  in  1  — instruction-memory write enable.
- `progAddr`  in  8  — instruction-memory write address.
- `progData`  in  21  — instruction-memory write data.
- `nPC`  out  8  — PC+1 of the instruction currently presented on `INS`.
- `INS`  out  21  — fetched instruction: {CTRL[20:17], rs1[16:14], rs2[13:11], rd[10:8], const[7:0]}.
- `PC`  out  8  — current program counter.
- `running`  out  1  — 1 in RUN.
- `halted`  out  1  — 1 in HALT.

## Operation

- Instruction memory: 256×21.
  - Synchronous write: when `progWE`=1 and state is IDLE or HALT. Writes in RUN are ignored.
  - Combinational read at `PC`.
  - Memory contents are not affected by `rst`.
- NOP is defined as {4'b1010, 17'b0}, the same bubble IF/ID inserts on flush.
- `INS` selection:
  - RUN: `INS` = mem[PC].
  - IDLE or HALT: `INS` = NOP.
- `nPC` = PC+1 mod 256 (255 → 0), combinational, in every state.
- FSM states: IDLE (reset), RUN, HALT.
  - IDLE --`start`--> RUN. On that edge PC<=0 and the pending redirect is cleared.
  - RUN --(CTRL==4'b1111 at PC, `IFstall`=0, `IFflush`=0, no pending redirect)--> HALT. PC holds at the halt instruction's address. The halt word itself is presented on `INS` in the cycle before the transition, so IF/ID captures it.
  - HALT --`start`--> RUN with PC<=0.
  - `rst` from any state → IDLE.
- PC update in RUN, first matching rule wins:
  1. `IFstall`=1 and `IFflush`=1: PC holds; capture `brTarget` into `pendTgt` and set `pendV`=1.
  2. `IFstall`=1: PC holds; `pendV`/`pendTgt` are unchanged.
  3. `IFflush`=1: PC<=`brTarget`; clear `pendV`. A new flush overrides a pending redirect.
  4. `pendV`=1: PC<=`pendTgt`; clear `pendV`.
  5. Otherwise: PC<=PC+1 mod 256.
- Halt detection does not fire while a stall, flush or pending redirect is active.
- Outside RUN, `IFstall`, `IFflush` and `brTarget` are ignored.
- `start` in RUN is ignored.

## Timing

- Reset (asynchronous, immediate):
  - PC=0, `nPC`=1, `INS`=NOP, state=IDLE, `running`=0, `halted`=0, `pendV`=0, `pendTgt`=0.
- Fetch latency: zero cycles. `INS` and `nPC` are valid combinationally from PC, and IF/ID samples them on the next edge.
- Redirect latency:
  - `IFflush` at edge k means PC=`brTarget` after edge k, so the target instruction is visible in cycle k+1.
  - A redirect buffered under stall takes effect on the first edge with `IFstall`=0.
- Memory write at edge k is readable from cycle k+1. A write to the current PC in IDLE/HALT has no visible effect until RUN.
- `start` at edge k: `running`=1 and `INS`=mem[0] in cycle k+1.
- Halt: halt word visible in cycle h. After edge h, `halted`=1, `INS`=NOP and PC frozen.

## Test plan

- Reset/start: `rst` pulse mid-RUN → PC=0, `INS`=NOP, `running`=0 immediately. Load mem[0..2]=0x0A1234, 0x012345, 0x1E0000, then pulse `start` → `INS` sequence 0x0A1234, 0x012345, 0x1E0000 with `nPC` 1,2,3. `halted`=1 afterwards, PC stays 2, `INS`=NOP.
- Stall: `IFstall`=1 for 3 cycles at PC=5 → PC, `INS` and `nPC` held at 5/mem[5]/6. PC=6 on the first edge after release.
- Flush: `IFflush`=1 with `brTarget`=0x40 at PC=7 → next cycle PC=0x40, `INS`=mem[0x40], `nPC`=0x41.
- Stall+flush: at PC=9, `IFstall`=`IFflush`=1 with `brTarget`=0x80 for 1 cycle, then `IFstall`=1 for 2 more cycles → PC stays 9. After release, PC=0x80 on the first free edge, then 0x81.
- Wrap/load guard:
  - Running from PC=0xFE → 0xFF, then 0x00 with `nPC`=0x01.
  - `progWE` in RUN to address 0x10 → mem[0x10] unchanged, checked after halt by a restart that fetches 0x10.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: run control, IF/ID hazard controls, program-load port and fetch outputs.
// master drives controls/loads; slave is the fetch stage presenting PC/nPC/INS.
interface instr_fetch_if;
  logic        start;
  logic        IFstall;
  logic        IFflush;
  logic [7:0]  brTarget;
  logic        progWE;
  logic [7:0]  progAddr;
  logic [20:0] progData;
  logic [7:0]  nPC;
  logic [20:0] INS;
  logic [7:0]  PC;
  logic        running;
  logic        halted;

  modport master (
    output start, IFstall, IFflush, brTarget, progWE, progAddr, progData,
    input  nPC, INS, PC, running, halted
  );

  modport slave (
    input  start, IFstall, IFflush, brTarget, progWE, progAddr, progData,
    output nPC, INS, PC, running, halted
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, 256x21 instruction memory and IDLE/RUN/HALT run control.
// Zero-cycle fetch (INS/nPC combinational from PC); stall holds PC, redirects under stall are buffered.
module instr_fetch (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.slave bus
);
  localparam logic [20:0] NOP       = {4'b1010, 17'b0};
  localparam logic [3:0]  CTRL_HALT = 4'b1111;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [7:0]  r_pend_tgt;
  logic        r_pend_v;
  logic [20:0] r_mem [256];
  logic [20:0] w_word;
  logic        w_run;

  assign w_run  = (r_state == RUN);
  assign w_word = r_mem[r_pc];

  // Program memory is loadable only while the core is not executing; not cleared by reset.
  always_ff @(posedge clk) begin
    if (bus.progWE && !w_run) begin
      r_mem[bus.progAddr] <= bus.progData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pc       <= 8'd0;
      r_pend_v   <= 1'b0;
      r_pend_tgt <= 8'd0;
    end else begin
      case (r_state)
        IDLE, HALT: begin
          if (bus.start) begin
            r_state  <= RUN;
            r_pc     <= 8'd0;
            r_pend_v <= 1'b0;
          end
        end
        RUN: begin
          if (bus.IFstall && bus.IFflush) begin
            r_pend_tgt <= bus.brTarget;
            r_pend_v   <= 1'b1;
          end else if (bus.IFstall) begin
            r_pc <= r_pc;
          end else if (bus.IFflush) begin
            r_pc     <= bus.brTarget;
            r_pend_v <= 1'b0;
          end else if (r_pend_v) begin
            r_pc     <= r_pend_tgt;
            r_pend_v <= 1'b0;
          end else if (w_word[20:17] == CTRL_HALT) begin
            // PC stays on the halt word's address.
            r_state <= HALT;
          end else begin
            r_pc <= r_pc + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.PC      = r_pc;
  assign bus.nPC     = r_pc + 8'd1;
  assign bus.INS     = w_run ? w_word : NOP;
  assign bus.running = w_run;
  assign bus.halted  = (r_state == HALT);
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then random traffic against a behavioural model.
module tb_instr_fetch;
  localparam logic [20:0] NOP = 21'h140000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  instr_fetch_if bus ();

  instr_fetch dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: memory array, integer PC, run/halt flags, queue for the buffered redirect.
  logic [20:0] m_mem [256];
  int          m_pc;
  bit          m_run;
  bit          m_halt;
  int          m_pend [$];
  logic [20:0] saved10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_pc"},  {24'd0, bus.PC},  m_pc);
    chk({tag, "_npc"}, {24'd0, bus.nPC}, (m_pc + 1) % 256);
    chk({tag, "_ins"}, {11'd0, bus.INS}, m_run ? {11'd0, m_mem[m_pc]} : {11'd0, NOP});
    chk({tag, "_run"}, {31'd0, bus.running}, {31'd0, m_run});
    chk({tag, "_hlt"}, {31'd0, bus.halted},  {31'd0, m_halt});
  endtask

  task automatic model_reset();
    m_pc = 0; m_run = 0; m_halt = 0; m_pend.delete();
  endtask

  task automatic model_edge();
    if (!m_run) begin
      if (bus.progWE) m_mem[bus.progAddr] = bus.progData;
      if (bus.start) begin
        m_run = 1; m_halt = 0; m_pc = 0; m_pend.delete();
      end
    end else if (bus.IFstall) begin
      if (bus.IFflush) begin
        m_pend.delete();
        m_pend.push_back(int'(bus.brTarget));
      end
    end else if (bus.IFflush) begin
      m_pc = int'(bus.brTarget);
      m_pend.delete();
    end else if (m_pend.size() > 0) begin
      m_pc = m_pend.pop_front();
    end else if (m_mem[m_pc][20:17] == 4'hF) begin
      m_run = 0; m_halt = 1;
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic load(input logic [7:0] a, input logic [20:0] d);
    bus.progWE = 1'b1; bus.progAddr = a; bus.progData = d;
    tick("load");
    bus.progWE = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick("start");
    bus.start = 1'b0;
  endtask

  task automatic flush_to(input logic [7:0] t);
    bus.IFflush = 1'b1; bus.brTarget = t;
    tick("flush");
    bus.IFflush = 1'b0;
  endtask

  function automatic logic [20:0] plain_word();
    logic [3:0] c;
    c = 4'($urandom_range(0, 14));
    return {c, 17'($urandom)};
  endfunction

  initial begin
    logic [20:0] w;
    bus.start = 0; bus.IFstall = 0; bus.IFflush = 0; bus.brTarget = 0;
    bus.progWE = 0; bus.progAddr = 0; bus.progData = 0;
    model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 'x;
    #1;
    chk_all("reset");
    #3 rst = 1'b0;

    // Program load: fixed boot words, halt words at 0x20/0x90, everything else non-halting.
    for (int a = 0; a < 256; a++) begin
      if (a == 0)                   w = 21'h0A1234;
      else if (a == 1)              w = 21'h012345;
      else if (a == 2)              w = 21'h1E0000;
      else if (a == 32 || a == 144) w = {4'hF, 17'($urandom)};
      else                          w = plain_word();
      load(8'(a), w);
    end

    // Reset in the middle of RUN takes effect without a clock edge.
    pulse_start();
    tick("run");
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_pc",  {24'd0, bus.PC}, 32'd0);
    chk("rst_ins", {11'd0, bus.INS}, {11'd0, NOP});
    chk("rst_run", {31'd0, bus.running}, 32'd0);
    rst = 1'b0;
    tick("post_rst");

    // Boot sequence ending on a halt word.
    pulse_start();
    chk("boot0_ins", {11'd0, bus.INS}, 32'h0A1234);
    chk("boot0_npc", {24'd0, bus.nPC}, 32'd1);
    tick("boot1");
    chk("boot1_ins", {11'd0, bus.INS}, 32'h012345);
    chk("boot1_npc", {24'd0, bus.nPC}, 32'd2);
    tick("boot2");
    chk("boot2_ins", {11'd0, bus.INS}, 32'h1E0000);
    chk("boot2_npc", {24'd0, bus.nPC}, 32'd3);
    tick("halt");
    tick("halt_hold");
    chk("halt_flag", {31'd0, bus.halted}, 32'd1);
    chk("halt_pc",   {24'd0, bus.PC}, 32'd2);
    chk("halt_ins",  {11'd0, bus.INS}, {11'd0, NOP});

    // Clear the halt at 2, restart and walk to PC 5 for the stall test.
    load(8'd2, plain_word());
    pulse_start();
    for (int i = 0; i < 5; i++) tick("walk");
    bus.IFstall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall_pc", {24'd0, bus.PC}, 32'd5);
    end
    bus.IFstall = 1'b0;
    tick("release");
    chk("release_pc", {24'd0, bus.PC}, 32'd6);
    tick("to7");
    flush_to(8'h40);
    chk("flush_pc",  {24'd0, bus.PC},  32'h40);
    chk("flush_npc", {24'd0, bus.nPC}, 32'h41);

    // Redirect arriving under stall is buffered until the stall drops.
    flush_to(8'd9);
    bus.IFstall = 1'b1; bus.IFflush = 1'b1; bus.brTarget = 8'h80;
    tick("stflush");
    bus.IFflush = 1'b0; bus.brTarget = 8'h00;
    tick("st2");
    tick("st3");
    chk("stflush_pc", {24'd0, bus.PC}, 32'd9);
    bus.IFstall = 1'b0;
    tick("pend");
    chk("pend_pc", {24'd0, bus.PC}, 32'h80);
    tick("pend_next");
    chk("pend_next_pc", {24'd0, bus.PC}, 32'h81);

    // PC wraps 0xFF -> 0x00.
    flush_to(8'hFE);
    tick("wrap_ff");
    chk("wrap_ff_pc", {24'd0, bus.PC}, 32'hFF);
    tick("wrap_00");
    chk("wrap_00_pc",  {24'd0, bus.PC},  32'h00);
    chk("wrap_00_npc", {24'd0, bus.nPC}, 32'h01);

    // Writes in RUN must be dropped; confirm by fetching 0x10 after a halt and restart.
    saved10 = m_mem[8'h10];
    bus.progWE = 1'b1; bus.progAddr = 8'h10; bus.progData = ~saved10;
    tick("run_write");
    bus.progWE = 1'b0;
    flush_to(8'h20);
    tick("halt20");
    chk("halt20_flag", {31'd0, bus.halted}, 32'd1);
    pulse_start();
    flush_to(8'h10);
    chk("guard_ins", {11'd0, bus.INS}, {11'd0, saved10});

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bus.IFstall  = ($urandom_range(0, 3) == 0);
      bus.IFflush  = ($urandom_range(0, 4) == 0);
      bus.brTarget = 8'($urandom);
      bus.progWE   = ($urandom_range(0, 5) == 0);
      bus.progAddr = 8'($urandom);
      bus.progData = ($urandom_range(0, 7) == 0) ? {4'hF, 17'($urandom)} : plain_word();
      bus.start    = m_run ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 40) == 0) bus.IFflush = 1'b1;
      if (bus.IFflush && $urandom_range(0, 6) == 0) bus.brTarget = 8'h90;
      tick("rand");
    end
    bus.start = 0; bus.IFstall = 0; bus.IFflush = 0; bus.progWE = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
